// File: rtl/div32s16_seq.sv
// Sequential signed divider: DW-bit dividend / VW-bit divisor, restoring radix-2.
// Ports: clock, reset, in_valid/in_ready/in_dividend/in_divisor, out_valid/out_ready/out_quotient/out_remainder/out_dbz/out_ovf.
module div32s16_seq #(
  parameter int DW = 32,
  parameter int VW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_dividend,
  input  logic [VW-1:0] in_divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_quotient,
  output logic [DW-1:0] out_remainder,
  output logic          out_dbz,
  output logic          out_ovf
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dq;
  logic [DW-1:0] prem;
  logic [DW:0]   vabs;
  logic          sd;
  logic          sv;
  logic          dbz;
  logic          ovf;

  logic [DW:0]   vext;
  logic [DW:0]   vmag;
  logic [DW-1:0] dmag;
  logic [DW:0]   trial;
  logic [DW:0]   diff;
  logic          is_ovf;

  assign in_ready = (state == IDLE);

  assign vext = {{(DW + 1 - VW){in_divisor[VW-1]}}, in_divisor};
  assign vmag = in_divisor[VW-1] ? -vext : vext;
  // Unsigned DW bits already hold 2^(DW-1), the magnitude of the most negative dividend.
  assign dmag = in_dividend[DW-1] ? -in_dividend : in_dividend;

  // dq shifts dividend bits out at the top and quotient bits in at the bottom.
  assign trial = {prem, dq[DW-1]};
  assign diff  = trial - vabs;

  assign is_ovf = (in_dividend == {1'b1, {(DW - 1){1'b0}}}) &&
                  (in_divisor == '1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      dq            <= '0;
      prem          <= '0;
      vabs          <= '0;
      sd            <= 1'b0;
      sv            <= 1'b0;
      dbz           <= 1'b0;
      ovf           <= 1'b0;
      out_valid     <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_dbz       <= 1'b0;
      out_ovf       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sd    <= in_dividend[DW-1];
            sv    <= in_divisor[VW-1];
            vabs  <= vmag;
            prem  <= '0;
            ovf   <= is_ovf;
            state <= CALC;
            if (in_divisor == '0) begin
              // Skip the iterations; the raw dividend is kept as the remainder.
              dbz <= 1'b1;
              dq  <= in_dividend;
              cnt <= CW'(DW);
            end else begin
              dbz <= 1'b0;
              dq  <= dmag;
              cnt <= '0;
            end
          end
        end
        CALC: begin
          if (cnt == CW'(DW)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_dbz   <= dbz;
            out_ovf   <= ovf;
            if (dbz) begin
              out_quotient  <= '1;
              out_remainder <= dq;
            end else begin
              out_quotient  <= (sd ^ sv) ? -dq : dq;
              out_remainder <= sd ? -prem : prem;
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (!diff[DW]) begin
              prem <= diff[DW-1:0];
              dq   <= {dq[DW-2:0], 1'b1};
            end else begin
              prem <= trial[DW-1:0];
              dq   <= {dq[DW-2:0], 1'b0};
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_dbz   <= 1'b0;
            out_ovf   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
